gpio_evt_fifo: RTL and testbench

GPIO_EVT_FIFO -- requirements
Module: gpio_evt_fifo

---
 rtl/gpio_evt_fifo.sv | 157 +++++++++++++++
 tb/tb_gpio_evt_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_evt_fifo.sv
// GPIO pin-change event FIFO: masked pin edges push {pins, timestamp} entries, drained over the local bus.
// Define GPIO_EVT_FIFO_TS_EN to build the timestamp counter and per-entry timestamp storage.
module gpio_evt_fifo #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] gpio_pin_q,
   input  logic        lb_wr,
   input  logic        lb_rd,
   input  logic [31:0] lb_addr,
   input  logic [31:0] lb_wr_d,
   output logic [31:0] lb_rd_d,
   output logic        lb_rd_rdy,
   output logic        evt_irq
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0]  ADDR_CTRL = 8'hA0;
   localparam logic [7:0]  ADDR_MASK = 8'hA4;
   localparam logic [7:0]  ADDR_STAT = 8'hA8;
   localparam logic [7:0]  ADDR_PINS = 8'hAC;
   localparam logic [7:0]  ADDR_TS   = 8'hB0;
   localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

   logic          lb_wr_p1, lb_rd_p1;
   logic [7:0]    lb_addr_p1;
   logic [31:0]   lb_wr_d_p1;
   logic          enable_reg, enable_next;
   logic [31:0]   mask_reg, mask_next;
   logic          overflow_reg, overflow_next;
   logic [31:0]   pins_prev_reg;
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   count_reg, count_next;
   logic [31:0]   rd_d_next;
   logic          rd_rdy_next, irq_next;
   logic [31:0]   pins_mem [DEPTH];
   logic [31:0]   head_ts;
   logic          is_empty, is_full, evt, clear, w1c, rd_ts, push_en, pop_en, drop;
   logic          unused_addr_hi;

   assign unused_addr_hi = &{1'b0, lb_addr[31:8]};

`ifdef GPIO_EVT_FIFO_TS_EN
   logic [31:0] ts_reg, ts_next;
   logic [31:0] ts_mem [DEPTH];

   assign head_ts = ts_mem[rd_ptr_reg];
   assign ts_next = clear ? 32'h0 : (enable_reg ? ts_reg + 32'h1 : ts_reg);

   always_ff @(posedge clk) begin
      if (!reset_n) ts_reg <= 32'h0;
      else          ts_reg <= ts_next;
   end

   always_ff @(posedge clk) begin
      if (push_en) ts_mem[wr_ptr_reg] <= ts_reg;
   end
`else
   assign head_ts = 32'h0;
`endif

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == COUNT_FULL);
   assign evt      = enable_reg && (((gpio_pin_q ^ pins_prev_reg) & mask_reg) != 32'h0);
   assign clear    = lb_wr_p1 && (lb_addr_p1 == ADDR_CTRL) && lb_wr_d_p1[1];
   assign w1c      = lb_wr_p1 && (lb_addr_p1 == ADDR_STAT) && lb_wr_d_p1[31];
   assign rd_ts    = lb_rd_p1 && (lb_addr_p1 == ADDR_TS);
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident push.
   assign pop_en   = rd_ts && !is_empty && !clear;
   assign push_en  = evt && !clear && (!is_full || pop_en);
   assign drop     = evt && !clear && is_full && !pop_en;

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      enable_next   = enable_reg;
      mask_next     = mask_reg;
      if (lb_wr_p1 && (lb_addr_p1 == ADDR_CTRL)) enable_next = lb_wr_d_p1[0];
      if (lb_wr_p1 && (lb_addr_p1 == ADDR_MASK)) mask_next = lb_wr_d_p1;
      if (clear) begin
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else begin
         if (push_en) wr_ptr_next = wr_ptr_reg + AW'(1);
         if (pop_en)  rd_ptr_next = rd_ptr_reg + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
         endcase
         if (drop)     overflow_next = 1'b1;
         else if (w1c) overflow_next = 1'b0;
      end
   end

   always_comb begin
      rd_d_next   = 32'h0;
      rd_rdy_next = 1'b0;
      if (lb_rd_p1) begin
         rd_rdy_next = 1'b1;
         case (lb_addr_p1)
            ADDR_CTRL: rd_d_next = {31'h0, enable_reg};
            ADDR_MASK: rd_d_next = mask_reg;
            ADDR_STAT: rd_d_next = {overflow_reg, is_empty, is_full, 20'h0, 9'(count_reg)};
            ADDR_PINS: rd_d_next = is_empty ? 32'h0 : pins_mem[rd_ptr_reg];
            ADDR_TS:   rd_d_next = is_empty ? 32'h0 : head_ts;
            default: begin
               rd_d_next   = 32'hDEADBEEF;
               rd_rdy_next = 1'b0;
            end
         endcase
      end
      irq_next = enable_next && (count_next != '0);
   end

   always_ff @(posedge clk) begin
      if (push_en) pins_mem[wr_ptr_reg] <= gpio_pin_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lb_wr_p1      <= 1'b0;
         lb_rd_p1      <= 1'b0;
         lb_addr_p1    <= 8'h0;
         lb_wr_d_p1    <= 32'h0;
         enable_reg    <= 1'b0;
         mask_reg      <= 32'h0;
         overflow_reg  <= 1'b0;
         pins_prev_reg <= 32'h0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         lb_rd_d       <= 32'h0;
         lb_rd_rdy     <= 1'b0;
         evt_irq       <= 1'b0;
      end else begin
         lb_wr_p1      <= lb_wr;
         lb_rd_p1      <= lb_rd;
         lb_addr_p1    <= lb_addr[7:0];
         lb_wr_d_p1    <= lb_wr_d;
         enable_reg    <= enable_next;
         mask_reg      <= mask_next;
         overflow_reg  <= overflow_next;
         pins_prev_reg <= gpio_pin_q;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         lb_rd_d       <= rd_d_next;
         lb_rd_rdy     <= rd_rdy_next;
         evt_irq       <= irq_next;
      end
   end
endmodule

// File: tb/tb_gpio_evt_fifo.sv
// Self-checking bench for gpio_evt_fifo: register table, directed corner sequences, random run vs queue model.
module tb_gpio_evt_fifo;
   localparam int DEPTH = 16;
   localparam logic [7:0] A_CTRL = 8'hA0, A_MASK = 8'hA4, A_STAT = 8'hA8, A_PINS = 8'hAC, A_TS = 8'hB0;
`ifdef GPIO_EVT_FIFO_TS_EN
   localparam logic [31:0] TS_MASK = 32'hFFFFFFFF;
`else
   localparam logic [31:0] TS_MASK = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] gpio_pin_q;
   logic        lb_wr, lb_rd;
   logic [31:0] lb_addr, lb_wr_d;
   logic [31:0] lb_rd_d;
   logic        lb_rd_rdy, evt_irq;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   gpio_evt_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .gpio_pin_q(gpio_pin_q),
      .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
      .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .evt_irq(evt_irq)
   );

   // Reference model: event queue plus registers, advanced once per rising edge.
   typedef struct { logic [31:0] pins; logic [31:0] ts; } ent_t;
   ent_t        m_q[$];
   logic        m_en, m_ovf;
   logic [31:0] m_mask, m_prev, m_ts;
   logic        mp_wr, mp_rd;
   logic [7:0]  mp_addr;
   logic [31:0] mp_d;
   logic [31:0] e_rd_d;
   logic        e_rdy, e_irq;

   task automatic model_step();
      logic [31:0] rdv;
      logic        rdy, evt, clr, w1c, pop, drop;
      if (!reset_n) begin
         m_q.delete();
         m_en = 0; m_ovf = 0; m_mask = 0; m_prev = 0; m_ts = 0;
         mp_wr = 0; mp_rd = 0; mp_addr = 0; mp_d = 0;
         e_rd_d = 0; e_rdy = 0; e_irq = 0;
         return;
      end
      rdv = 0; rdy = 0;
      if (mp_rd) begin
         rdy = 1;
         case (mp_addr)
            A_CTRL: rdv = {31'h0, m_en};
            A_MASK: rdv = m_mask;
            A_STAT: rdv = {m_ovf, m_q.size() == 0, m_q.size() == DEPTH, 20'h0, 9'(m_q.size())};
            A_PINS: rdv = (m_q.size() > 0) ? m_q[0].pins : 32'h0;
            A_TS:   rdv = (m_q.size() > 0) ? (m_q[0].ts & TS_MASK) : 32'h0;
            default: begin rdv = 32'hDEADBEEF; rdy = 0; end
         endcase
      end
      evt  = m_en && (((gpio_pin_q ^ m_prev) & m_mask) != 0);
      clr  = mp_wr && mp_addr == A_CTRL && mp_d[1];
      w1c  = mp_wr && mp_addr == A_STAT && mp_d[31];
      pop  = mp_rd && mp_addr == A_TS && m_q.size() > 0;
      drop = 0;
      if (clr) begin
         m_q.delete(); m_ts = 0; m_ovf = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (evt) begin
            if (m_q.size() < DEPTH) m_q.push_back('{pins: gpio_pin_q, ts: m_ts});
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (w1c) m_ovf = 0;
         if (m_en) m_ts = m_ts + 1;
      end
      if (mp_wr && mp_addr == A_CTRL) m_en = mp_d[0];
      if (mp_wr && mp_addr == A_MASK) m_mask = mp_d;
      m_prev = gpio_pin_q;
      mp_wr = lb_wr; mp_rd = lb_rd; mp_addr = lb_addr[7:0]; mp_d = lb_wr_d;
      e_rd_d = rdv; e_rdy = rdy; e_irq = m_en && m_q.size() > 0;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check("model_rd_d", lb_rd_d, e_rd_d);
      check("model_rdy", 32'(lb_rd_rdy), 32'(e_rdy));
      check("model_irq", 32'(evt_irq), 32'(e_irq));
   endtask

   task automatic set_addr(input logic [7:0] a);
      logic [31:0] hi;
      hi = $urandom();
      lb_addr = {hi[31:8], a};
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      lb_wr = 1; set_addr(a); lb_wr_d = d;
      tick();
      lb_wr = 0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic r);
      lb_rd = 1; set_addr(a);
      tick();
      lb_rd = 0;
      tick();
      d = lb_rd_d; r = lb_rd_rdy;
   endtask

   task automatic expect_read(input string nm, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        r;
      bus_read(a, d, r);
      check(nm, d, exp);
   endtask

   typedef struct { bit wr; logic [7:0] addr; logic [31:0] d; logic [31:0] exp_d; bit exp_rdy; } vec_t;
   vec_t tbl[14];

   initial begin
      logic [31:0] pins, rd, t0, t1, newest, pd, r;
      logic        rr;
      logic [7:0]  maps[5];

      tbl[0]  = '{0, A_CTRL, 32'h0,        32'h0,        1};
      tbl[1]  = '{0, A_MASK, 32'h0,        32'h0,        1};
      tbl[2]  = '{0, A_STAT, 32'h0,        32'h40000000, 1};
      tbl[3]  = '{0, A_TS,   32'h0,        32'h0,        1};
      tbl[4]  = '{0, 8'h10,  32'h0,        32'hDEADBEEF, 0};
      tbl[5]  = '{1, A_MASK, 32'h000000F0, 32'h0,        0};
      tbl[6]  = '{0, A_MASK, 32'h0,        32'h000000F0, 1};
      tbl[7]  = '{0, 8'hA6,  32'h0,        32'hDEADBEEF, 0};
      tbl[8]  = '{0, 8'hB4,  32'h0,        32'hDEADBEEF, 0};
      tbl[9]  = '{1, A_CTRL, 32'h00000002, 32'h0,        0};
      tbl[10] = '{0, A_CTRL, 32'h0,        32'h0,        1};
      tbl[11] = '{1, A_MASK, 32'h00000001, 32'h0,        0};
      tbl[12] = '{0, A_MASK, 32'h0,        32'h00000001, 1};
      tbl[13] = '{0, 8'h9C,  32'h0,        32'hDEADBEEF, 0};
      maps = '{A_CTRL, A_MASK, A_STAT, A_PINS, A_TS};

      pins = 0;
      reset_n = 0; gpio_pin_q = 0; lb_wr = 0; lb_rd = 0; lb_addr = 0; lb_wr_d = 0;
      repeat (3) tick();
      check("rst_rd_d", lb_rd_d, 32'h0);
      check("rst_irq", 32'(evt_irq), 32'h0);
      reset_n = 1;
      tick();

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].d);
         else begin
            bus_read(tbl[i].addr, rd, rr);
            check($sformatf("tbl%0d_d", i), rd, tbl[i].exp_d);
            check($sformatf("tbl%0d_rdy", i), 32'(rr), 32'(tbl[i].exp_rdy));
         end
      end

      // Two edges on pin 0, five clocks apart.
      bus_write(A_CTRL, 32'h1);
      tick();
      pins = 32'h1; gpio_pin_q = pins; tick();
      repeat (4) tick();
      pins = 32'h0; gpio_pin_q = pins; tick();
      check("two_irq", 32'(evt_irq), 32'h1);
      expect_read("two_stat", A_STAT, 32'h00000002);
      expect_read("two_pins0", A_PINS, 32'h1);
      bus_read(A_TS, t0, rr);
      expect_read("two_pins1", A_PINS, 32'h0);
      bus_read(A_TS, t1, rr);
      check("two_ts_delta", t1 - t0, TS_MASK & 32'd5);

      // Unmasked pin activity is ignored.
      bus_write(A_CTRL, 32'h3);
      tick();
      pins = 32'h10; gpio_pin_q = pins; tick();
      pins = 32'h0;  gpio_pin_q = pins; tick();
      tick();
      check("nomask_irq", 32'(evt_irq), 32'h0);
      expect_read("nomask_stat", A_STAT, 32'h40000000);

      // Overfill by one, then W1C of overflow (also coincident with another drop).
      for (int i = 0; i < 17; i++) begin
         pins = pins ^ 32'h1; gpio_pin_q = pins; tick();
      end
      check("full_irq", 32'(evt_irq), 32'h1);
      expect_read("full_stat", A_STAT, 32'hA0000010);
      lb_wr = 1; set_addr(A_STAT); lb_wr_d = 32'h80000000;
      tick();
      lb_wr = 0; pins = pins ^ 32'h1; gpio_pin_q = pins;
      tick();
      expect_read("w1c_race_stat", A_STAT, 32'hA0000010);
      bus_write(A_STAT, 32'h80000000);
      expect_read("w1c_stat", A_STAT, 32'h20000010);

      // Full FIFO: pop and push in the same cycle.
      lb_rd = 1; set_addr(A_TS);
      tick();
      lb_rd = 0; pins = pins ^ 32'h1; gpio_pin_q = pins; newest = pins;
      tick();
      tick();
      expect_read("pushpop_stat", A_STAT, 32'h20000010);
      pd = 32'hFFFFFFFF;
      for (int i = 0; i < DEPTH; i++) begin
         bus_read(A_PINS, pd, rr);
         bus_read(A_TS, r, rr);
      end
      check("pushpop_tail", pd, newest);
      expect_read("drain_stat", A_STAT, 32'h40000000);

      // Empty pop and unmapped read.
      bus_read(A_TS, rd, rr);
      check("empty_ts_d", rd, 32'h0);
      check("empty_ts_rdy", 32'(rr), 32'h1);
      bus_read(8'h10, rd, rr);
      check("unmap_d", rd, 32'hDEADBEEF);
      check("unmap_rdy", 32'(rr), 32'h0);
      tick();
      check("idle_rd_d", lb_rd_d, 32'h0);

      // Clear with entries queued, timestamp restart.
      for (int i = 0; i < 3; i++) begin
         pins = pins ^ 32'h1; gpio_pin_q = pins; tick();
      end
      expect_read("pre_clr_stat", A_STAT, 32'h00000003);
      bus_write(A_CTRL, 32'h3);
      tick();
      expect_read("clr_stat", A_STAT, 32'h40000000);
      pins = pins ^ 32'h1; gpio_pin_q = pins; tick();
      expect_read("clr_ts", A_TS, TS_MASK & 32'd2);

      // Reset mid-stream with a read in flight.
      for (int i = 0; i < 3; i++) begin
         pins = pins ^ 32'h1; gpio_pin_q = pins; tick();
      end
      lb_rd = 1; set_addr(A_STAT);
      tick();
      lb_rd = 0; reset_n = 0;
      tick();
      check("rst_mid_rd_d", lb_rd_d, 32'h0);
      check("rst_mid_rdy", 32'(lb_rd_rdy), 32'h0);
      check("rst_mid_irq", 32'(evt_irq), 32'h0);
      tick();
      reset_n = 1;
      tick();
      expect_read("rst_mid_stat", A_STAT, 32'h40000000);
      expect_read("rst_mid_ctrl", A_CTRL, 32'h0);
      expect_read("rst_mid_mask", A_MASK, 32'h0);

      // Random traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         if (r[3:0] < 4'd5) pins = pins ^ {24'h0, r[11:4]};
         if (r[15:12] == 4'd0) pins = $urandom();
         gpio_pin_q = pins;
         lb_wr = 0; lb_rd = 0; lb_wr_d = $urandom();
         case ($urandom_range(0, 11))
            0, 1, 2: begin lb_rd = 1; set_addr(maps[$urandom_range(0, 4)]); end
            3:       begin lb_rd = 1; set_addr(8'($urandom_range(0, 255))); end
            4:       begin
               lb_wr = 1; set_addr(A_CTRL);
               lb_wr_d = {30'h0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0};
            end
            5:       begin lb_wr = 1; set_addr(A_MASK); lb_wr_d = lb_wr_d & 32'h800000FF; end
            6:       begin lb_wr = 1; set_addr(A_STAT); end
            7, 8:    begin lb_rd = 1; set_addr(A_TS); end
            9:       begin lb_wr = 1; set_addr(8'($urandom_range(0, 255))); end
            default: ;
         endcase
         tick();
      end
      lb_wr = 0; lb_rd = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
